// File: rtl/bcd_display_scanner.sv
// Scans NUM_DIGITS double-buffered BCD digits onto one shared active-low 7-segment bus with anode strobes.
// seg_n/an_n are registered (1 clock behind prescaler/index state); no backpressure, free-running scan.
module bcd_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    load,
  input  logic                    display_en,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [3:0]              cur_dig;
  logic                    lz_blank;
  logic                    blink_bit;
  logic                    upper_zero;
  logic [6:0]              seg_dec;
  logic                    blank;

  // Scan sequencing and tear-free display update.
  always_comb begin
    shadow_d      = load ? digits_bcd : shadow_q;
    disp_d        = disp_q;
    presc_d       = presc_q + 1'b1;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_done_d  = 1'b0;
    slot_end      = (presc_q == PRESC_LAST);
    frame_wrap    = slot_end && (idx_q == IDX_LAST);

    if (slot_end) begin
      presc_d = '0;
      idx_d   = frame_wrap ? '0 : idx_q + 1'b1;
    end

    // Display copy takes the pre-edge shadow, so a load on the wrap edge waits a frame.
    if (frame_wrap) begin
      disp_d       = shadow_q;
      frame_done_d = 1'b1;
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Current digit select plus leading-zero run scanned from the most significant digit down.
  always_comb begin
    cur_dig    = 4'd0;
    lz_blank   = 1'b0;
    blink_bit  = 1'b0;
    upper_zero = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        cur_dig   = disp_q[4*i +: 4];
        lz_blank  = upper_zero && (i != 0);
        blink_bit = blink_mask[i];
      end
    end
  end

  always_comb begin
    case (cur_dig)
      4'd0:    seg_dec = 7'b0000001;
      4'd1:    seg_dec = 7'b1001111;
      4'd2:    seg_dec = 7'b0010010;
      4'd3:    seg_dec = 7'b0000110;
      4'd4:    seg_dec = 7'b1001100;
      4'd5:    seg_dec = 7'b0100100;
      4'd6:    seg_dec = 7'b0100000;
      4'd7:    seg_dec = 7'b0001101;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0000100;
      default: seg_dec = 7'b1111111;
    endcase

    blank   = !display_en || (blink_bit && blink_phase_q) || lz_blank;
    seg_n_d = blank ? 7'b1111111 : seg_dec;
    // Anodes stay dark for the first cycle of every slot to avoid ghosting between digits.
    an_n_d  = (!display_en || (presc_q == '0)) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      disp_q        <= '0;
      presc_q       <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_done_q  <= 1'b0;
      seg_n_q       <= 7'b1111111;
      an_n_q        <= '1;
    end else begin
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_done_q  <= frame_done_d;
      seg_n_q       <= seg_n_d;
      an_n_q        <= an_n_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: 4 digits, 4 clocks per slot, 2-frame blink half-period.
module tb_bcd_display_scanner;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001101;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SB = 7'b1111111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*ND-1:0] digits_bcd = '0;
  logic            load = 1'b0;
  logic            display_en = 1'b1;
  logic            blank_lz = 1'b0;
  logic [ND-1:0]   blink_mask = '0;
  logic [6:0]      seg_n;
  logic [ND-1:0]   an_n;
  logic            frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0]     dig;
    logic            lz;
    logic [3:0][6:0] seg;
  } vec_t;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          chk_seg;
  } exp_t;

  exp_t sb[$];
  vec_t vt[8];

  bcd_display_scanner #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_bcd(digits_bcd),
    .load      (load),
    .display_en(display_en),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [15:0] dig, input logic lz,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.dig = dig;
    v.lz  = lz;
    v.seg = {s3, s2, s1, s0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b, required %0b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Queue the 16 per-cycle expectations of one full frame.
  task automatic push_frame(input logic [3:0][6:0] seg, input logic en);
    for (int k = 0; k < FRAME; k++) begin
      exp_t e;
      int   s;
      int   p;
      s         = k / SD;
      p         = k % SD;
      e.an      = (!en || p == 0) ? {ND{1'b1}} : ~(ND'(1) << s);
      e.seg     = en ? seg[s] : SB;
      e.chk_seg = !en || (p != 0);
      sb.push_back(e);
    end
  endtask

  // Starts at the negedge right after a frame wrap; optionally pulses load at cycle load_at.
  task automatic run_frame(input int load_at, input logic [15:0] load_val);
    for (int k = 0; k < FRAME; k++) begin
      if (k == load_at) begin
        digits_bcd = load_val;
        load       = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue at k=%0d, required an entry", k);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("an_n k=%0d", k), an_n, e.an);
        if (e.chk_seg) check($sformatf("seg_n k=%0d", k), seg_n, e.seg);
        check($sformatf("frame_done k=%0d", k), frame_done, k == FRAME - 1);
      end
    end
    load = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] v);
    digits_bcd = v;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 3 * FRAME);
    check("wait_frame_done", frame_done, 1);
  endtask

  initial begin
    int n;

    vt[0] = mk(16'h1234, 1'b0, S1, S2, S3, S4);
    vt[1] = mk(16'h0051, 1'b1, SB, SB, S5, S1);
    vt[2] = mk(16'h0000, 1'b1, SB, SB, SB, S0);
    vt[3] = mk(16'h0501, 1'b1, SB, S5, S0, S1);
    vt[4] = mk(16'h00A0, 1'b0, S0, S0, SB, S0);
    vt[5] = mk(16'h6789, 1'b0, S6, S7, S8, S9);
    vt[6] = mk(16'h0000, 1'b0, S0, S0, S0, S0);
    vt[7] = mk(16'hFB05, 1'b1, SB, SB, S0, S5);

    // Reset values while clocks run.
    repeat (3) @(negedge clk);
    check("reset seg_n", seg_n, 7'h7f);
    check("reset an_n", an_n, 4'hf);
    check("reset frame_done", frame_done, 0);

    // First frame_done arrives 16 clocks after release.
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 4 * FRAME);
    check("first frame_done clocks", n, FRAME);

    // Display register cleared by reset shows zeros.
    push_frame({S0, S0, S0, S0}, 1'b1);
    run_frame(-1, 16'h0);

    foreach (vt[i]) begin
      blank_lz = vt[i].lz;
      load_word(vt[i].dig);
      push_frame(vt[i].seg, 1'b1);
      wait_frame();
      run_frame(-1, 16'h0);
    end

    // Tear-free update: mid-frame load, then a load on the wrap edge itself.
    blank_lz = 1'b0;
    load_word(16'h1234);
    wait_frame();
    push_frame({S1, S2, S3, S4}, 1'b1);
    run_frame(-1, 16'h0);
    push_frame({S1, S2, S3, S4}, 1'b1);
    run_frame(5, 16'h9999);
    push_frame({S9, S9, S9, S9}, 1'b1);
    run_frame(FRAME - 1, 16'h1234);
    push_frame({S9, S9, S9, S9}, 1'b1);
    run_frame(-1, 16'h0);
    push_frame({S1, S2, S3, S4}, 1'b1);
    run_frame(-1, 16'h0);

    // Scan continues dark with display_en low.
    display_en = 1'b0;
    push_frame({S1, S2, S3, S4}, 1'b0);
    run_frame(-1, 16'h0);
    display_en = 1'b1;

    // Asynchronous reset during slot 2.
    repeat (10) @(negedge clk);
    check("pre-reset slot2 an_n", an_n, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("async reset seg_n", seg_n, 7'h7f);
    check("async reset an_n", an_n, 4'hf);
    check("async reset frame_done", frame_done, 0);
    @(negedge clk);
    blink_mask = 4'b0001;
    rst_n      = 1'b1;
    @(negedge clk);
    check("restart dead-time an_n", an_n, 4'hf);
    @(negedge clk);
    check("restart first an_n", an_n, 4'b1110);
    check("restart first seg_n", seg_n, S0);

    // Blink on digit 0: frame f after reset has phase (f/2)%2.
    load_word(16'h1234);
    wait_frame();
    for (int f = 1; f <= 8; f++) begin
      push_frame({S1, S2, S3, (((f / 2) % 2) == 1) ? SB : S4}, 1'b1);
      run_frame(-1, 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
